// File: rtl/nrs_pkg.sv
// Shared constants, FSM encoding and factor helper for the NB-IoT NRS seed blocks.
package nrs_pkg;

  localparam int CINIT_W     = 31;
  localparam int A_W         = 8;
  localparam int B_W         = 10;
  localparam int NUM_RUNS    = 4;
  localparam int P_W         = A_W + B_W;
  localparam int RUN_W       = 2;
  localparam int CINIT_SHIFT = 10;
  localparam int NPSS_SF     = 5;
  localparam int NSSS_SF     = 9;
  localparam int MAX_CELL_ID = 503;
  localparam int L_FIRST     = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_LOAD,
    ST_MULT,
    ST_DONE
  } state_e;

  // Run bit 1 picks the second slot of the subframe, run bit 0 picks symbol 6 over 5.
  function automatic logic [A_W-1:0] calc_factor_a(input logic [3:0] sf, input logic [RUN_W-1:0] run);
    int ns;
    int l;
    ns = 2 * int'(sf) + int'(run[1]);
    l  = L_FIRST + int'(run[0]);
    return A_W'(7 * (ns + 1) + l + 1);
  endfunction

endpackage

// File: rtl/nrs_shift_add_mult.sv
// Sequential LSB-first shift-add multiplier, A_W iterations per product.
// done_o is high during the final iteration; product_o then already includes that last partial sum.
module nrs_shift_add_mult
  import nrs_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic           done_o,
  output logic [P_W-1:0] product_o
);

  localparam int CNT_W = $clog2(A_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(A_W - 1);

  logic [A_W-1:0]   a_q;
  logic [P_W-1:0]   b_q;
  logic [P_W-1:0]   acc_q;
  logic [P_W-1:0]   acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  assign acc_d     = acc_q + (a_q[0] ? b_q : '0);
  assign product_o = acc_d;
  assign done_o    = busy_q && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= P_W'(b_i);
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      a_q   <= a_q >> 1;
      b_q   <= b_q << 1;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/nrs_cinit_scheduler.sv
// Per-subframe NRS c_init sequencer: gates NRS subframes and serves four seeds per subframe.
// Optional macro NRS_SKIP_SYNC_SF_EN marks the NPSS/NSSS subframes as non-NRS.
module nrs_cinit_scheduler
  import nrs_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               sf_start,
  input  logic [3:0]         sf_num,
  input  logic               frame_even,
  input  logic [8:0]         n_cell_id,
  input  logic               cinit_run,
  output logic               nrs_new_frame,
  output logic [CINIT_W-1:0] cinit,
  output logic               cinit_valid,
  output logic               last_run,
  output logic               sf_skip,
  output logic               busy,
  output logic               run_err
);

  state_e             state_q;
  logic [RUN_W-1:0]   run_q;
  logic [3:0]         cfg_sf_q;
  logic [8:0]         cfg_id_q;
  logic               new_frame_q;
  logic               skip_q;
  logic [CINIT_W-1:0] cinit_q;
  logic [CINIT_W-1:0] cinit_d;
  logic               valid_q;
  logic               last_q;
  logic               busy_q;
  logic               err_q;

  logic               nrs_sf;
  logic [A_W-1:0]     factor_a;
  logic [B_W-1:0]     factor_b;
  logic               mult_done;
  logic [P_W-1:0]     mult_product;

`ifdef NRS_SKIP_SYNC_SF_EN
  assign nrs_sf = (sf_num <= 4'd9) && (sf_num != 4'(NPSS_SF)) &&
                  !((sf_num == 4'(NSSS_SF)) && frame_even);
`else
  logic unused_frame_even;
  assign unused_frame_even = frame_even;
  assign nrs_sf = (sf_num <= 4'd9);
`endif

  assign factor_a = calc_factor_a(cfg_sf_q, run_q);
  assign factor_b = {cfg_id_q, 1'b1};
  assign cinit_d  = CINIT_W'({mult_product, {CINIT_SHIFT{1'b0}}}) + CINIT_W'(factor_b);

  nrs_shift_add_mult u_mult (
    .clk       (clk),
    .rst       (rst),
    .start_i   (state_q == ST_LOAD),
    .abort_i   (sf_start),
    .a_i       (factor_a),
    .b_i       (factor_b),
    .done_o    (mult_done),
    .product_o (mult_product)
  );

  // A new subframe boundary overrides everything, including a multiply in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      run_q       <= '0;
      cfg_sf_q    <= '0;
      cfg_id_q    <= '0;
      new_frame_q <= 1'b0;
      skip_q      <= 1'b0;
      cinit_q     <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      new_frame_q <= 1'b0;
      skip_q      <= 1'b0;
      valid_q     <= 1'b0;
      if (sf_start) begin
        cfg_sf_q <= sf_num;
        cfg_id_q <= n_cell_id;
        run_q    <= '0;
        last_q   <= 1'b0;
        busy_q   <= 1'b0;
        if (nrs_sf) begin
          state_q     <= ST_ARMED;
          new_frame_q <= 1'b1;
        end else begin
          state_q <= ST_IDLE;
          skip_q  <= 1'b1;
        end
      end else begin
        if (cinit_run && (state_q != ST_ARMED)) begin
          err_q <= 1'b1;
        end
        case (state_q)
          ST_IDLE: state_q <= ST_IDLE;
          ST_ARMED: begin
            if (cinit_run) begin
              state_q <= ST_LOAD;
              busy_q  <= 1'b1;
            end
          end
          ST_LOAD: state_q <= ST_MULT;
          ST_MULT: begin
            if (mult_done) begin
              cinit_q <= cinit_d;
              valid_q <= 1'b1;
              last_q  <= (run_q == RUN_W'(NUM_RUNS - 1));
              run_q   <= run_q + 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end
          end
          ST_DONE: state_q <= last_q ? ST_IDLE : ST_ARMED;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign nrs_new_frame = new_frame_q;
  assign cinit         = cinit_q;
  assign cinit_valid   = valid_q;
  assign last_run      = last_q;
  assign sf_skip       = skip_q;
  assign busy          = busy_q;
  assign run_err       = err_q;

endmodule
